multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle combinational control with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. All datapath strobes and mux selects are driven from this one block. It sits between the instruction register/ALU flags and the PC, IR, register file, ALU muxes and the shared instruction/data memory port. It also counts retired instructions and halts on illegal opcodes or memory timeouts.

## Interface
- MEM_TIMEOUT, 255: maximum cycles any memory state waits for mem_ready before halting; range 1..65535.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  instruction[31:26] from IR
- zf  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_we  out  1  PC load strobe
- pc_src  out  2  PC source select: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- ir_we  out  1  IR load strobe
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = ext imm, 11 = ext imm<<2
- alu_op  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct, 11 = opcode
- ext_op  out  1  1 = sign-extend, 0 = zero-extend
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- instr_count  out  32  retired instruction count
- err  out  1  sticky halt flag
- state  out  4  current state encoding

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, HALT=12.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00; pc_we = ir_we = mem_ready.
  - Waits in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, ext_op=1, alu_op=00.
  - Next state by opcode:
    - 000000 → EXEC_R
    - 100011 or 101011 → MEM_ADDR
    - 001000, 001001, 001100, 001101 → EXEC_I
    - 000100 or 000101 → BRANCH
    - 000010 → JUMP
    - any other opcode → HALT
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, ext_op=1.
  - Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - On mem_ready → MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: mem_write=1, i_or_d=1.
  - On mem_ready → FETCH.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_op=10.
  - Next state: WB_R.
- WB_R:
  - Outputs: reg_write=1, reg_dst=1.
  - Next state: FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=11; ext_op=1 for addi/addiu, 0 for andi/ori.
  - Next state: WB_I.
- WB_I:
  - Outputs: reg_write=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_op=01, pc_src=01.
  - pc_we = zf for beq, ~zf for bne (combinational on zf).
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_src=10, pc_we=1.
  - Next state: FETCH.
- HALT:
  - All outputs 0 except err=1 and state=12.
  - Only reset exits HALT.
- Opcode is sampled every cycle. The IR holds it stable from DECODE until the next FETCH completes.
- instr_done is high in:
  - MEM_WB, WB_R, WB_I, BRANCH, JUMP;
  - MEM_WR when mem_ready=1.
- instr_count increments by 1 on each instr_done and wraps from 0xFFFFFFFF to 0 without a flag.
- Memory timeout:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle that state waits with mem_ready=0.
  - When it reaches MEM_TIMEOUT while still waiting, the next state is HALT and err is set.
  - mem_ready arriving on the cycle the count reaches MEM_TIMEOUT wins: the access completes normally.

## Timing
- Reset, while asserted:
  - state=FETCH, instr_count=0, err=0, wait counter=0.
  - pc_we, ir_we, mem_read, mem_write, reg_write, instr_done are forced to 0.
  - Selects take their FETCH values: alu_src_b=01, all others 0.
- First fetch request (mem_read=1) is in the first cycle after reset deasserts.
- Latency with zero memory wait (mem_ready=1 on the first request cycle):
  - R-type / I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne/j: 3 cycles
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset asserted mid-instruction aborts immediately. No partial write strobe is issued after reset rises.
- All state, counter and flag updates happen on the rising clk edge. Outputs are Moore-decoded from state, except pc_we in FETCH/BRANCH and ir_we/instr_done, which combine with mem_ready/zf.

## Test plan
- add (opcode 000000), mem_ready tied 1 → states 0,1,6,7; reg_write=1 with reg_dst=1 in cycle 4; instr_done pulses once; instr_count=1.
- lw with mem_ready low for 3 cycles in MEM_RD → total 8 cycles; one reg_write with mem_to_reg=1; no write during the waits.
- beq with zf=1, then beq with zf=0, then bne with zf=0 → pc_we=1, 0, 1 in the respective BRANCH cycles; pc_src=01 in all three.
- Opcode 111111 → DECODE then HALT; err=1 and held for 100 cycles; instr_count unchanged; reset clears err and returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT after 4 wait cycles; repeat with mem_ready=1 on wait cycle 4 → DECODE, no err.
- instr_count preset near 0xFFFFFFFF via forced sequence of 2 j instructions → wraps to 0x00000000 then 0x00000001; reset asserted in EXEC_R → no reg_write issued.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multi-cycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback, drives all datapath strobes and mux selects, counts retired
// instructions and halts on illegal opcodes or memory timeouts.
//
// Ports
//   clk, reset           rising-edge clock, async active-high reset
//   opcode               instruction[31:26] from IR
//   zf                   ALU zero flag
//   mem_ready            memory completes the current access this cycle
//   pc_we, pc_src        PC load strobe / source select
//   ir_we                IR load strobe
//   i_or_d               memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write  memory requests
//   reg_dst, mem_to_reg  register file write address / data selects
//   reg_write            register file write enable
//   alu_src_a/b, alu_op  ALU operand selects and ALU control
//   ext_op               1 = sign-extend immediate
//   instr_done           pulse on the last cycle of each instruction
//   instr_count          retired instruction count (wraps)
//   err                  sticky halt flag
//   state                current state encoding
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zf,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        ext_op,
    output logic        instr_done,
    output logic [31:0] instr_count,
    output logic        err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        EXEC_I   = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    state_t      cur, nxt;
    logic [15:0] wait_cnt;
    logic [31:0] instr_cnt_q;
    logic        err_q;
    logic        in_wait;
    logic        timed_out;

    // States that hold on mem_ready and are subject to the timeout.
    assign in_wait   = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
    // The wait that would bring the count to MEM_TIMEOUT is the last one
    // allowed; a mem_ready in that same cycle still completes the access.
    assign timed_out = (wait_cnt == 16'(MEM_TIMEOUT - 1));

    always_comb begin
        nxt        = cur;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        ir_we      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        ext_op     = 1'b0;
        instr_done = 1'b0;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_we     = mem_ready;
                ir_we     = mem_ready;
                if (mem_ready)      nxt = DECODE;
                else if (timed_out) nxt = HALT;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (opcode)
                    6'b000000:                      nxt = EXEC_R;
                    6'b100011, 6'b101011:           nxt = MEM_ADDR;
                    6'b001000, 6'b001001,
                    6'b001100, 6'b001101:           nxt = EXEC_I;
                    6'b000100, 6'b000101:           nxt = BRANCH;
                    6'b000010:                      nxt = JUMP;
                    default:                        nxt = HALT;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                // lw = 100011, sw = 101011: bit 3 separates them
                nxt       = opcode[3] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)      nxt = MEM_WB;
                else if (timed_out) nxt = HALT;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready)      nxt = FETCH;
                else if (timed_out) nxt = HALT;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt       = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                // addi/addiu (0010x0/0010x1) sign-extend, andi/ori zero-extend
                ext_op    = ~opcode[2];
                nxt       = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                // beq = 000100, bne = 000101
                pc_we      = opcode[0] ? ~zf : zf;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                nxt        = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = HALT;
        endcase
        // Reset is asynchronous: kill every strobe the moment it rises so no
        // partial write leaks out before the state register clears.
        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            instr_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            cur         <= nxt;
            // Staying in a wait state only happens without mem_ready, so
            // clearing otherwise also clears it on entry to the next wait.
            wait_cnt    <= (in_wait && !mem_ready) ? wait_cnt + 16'd1 : '0;
            instr_cnt_q <= instr_cnt_q + {31'd0, instr_done};
            if (nxt == HALT) err_q <= 1'b1;
        end
    end

    assign instr_count = instr_cnt_q;
    assign err         = err_q;
    assign state       = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zf;
    logic        mem_ready;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        ext_op;
    logic        instr_done;
    logic [31:0] instr_count;
    logic        err;
    logic [3:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
        .instr_done(instr_done), .instr_count(instr_count), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From FETCH (mem_ready=1): FETCH, DECODE, BRANCH, back to FETCH.
    task automatic do_branch(input string tag, input logic [5:0] op, input logic z,
                             input logic exp_pc_we);
        opcode = op;
        zf     = z;
        tick;
        tick;
        chk({tag, "_state"}, 32'(state), 32'd10);
        chk({tag, "_pc_we"}, 32'(pc_we), 32'(exp_pc_we));
        chk({tag, "_pc_src"}, 32'(pc_src), 32'd1);
        chk({tag, "_done"}, 32'(instr_done), 32'd1);
        tick;
    endtask

    initial begin
        int bad;
        reset = 1'b1; opcode = 6'd0; zf = 1'b0; mem_ready = 1'b1;
        tick; tick;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_ir_we", 32'(ir_we), 32'd0);
        chk("rst_done", 32'(instr_done), 32'd0);
        chk("rst_srcb", 32'(alu_src_b), 32'd1);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // add: states 0,1,6,7
        reset = 1'b0; #1;
        chk("add_f_mem_read", 32'(mem_read), 32'd1);
        chk("add_f_ir_we", 32'(ir_we), 32'd1);
        chk("add_f_pc_we", 32'(pc_we), 32'd1);
        tick;
        chk("add_d_state", 32'(state), 32'd1);
        chk("add_d_srcb", 32'(alu_src_b), 32'd3);
        chk("add_d_ext", 32'(ext_op), 32'd1);
        tick;
        chk("add_x_state", 32'(state), 32'd6);
        chk("add_x_aluop", 32'(alu_op), 32'd2);
        chk("add_x_srca", 32'(alu_src_a), 32'd1);
        tick;
        chk("add_wb_state", 32'(state), 32'd7);
        chk("add_wb_rw", 32'(reg_write), 32'd1);
        chk("add_wb_dst", 32'(reg_dst), 32'd1);
        chk("add_wb_done", 32'(instr_done), 32'd1);
        tick;
        chk("add_cnt", instr_count, 32'd1);
        chk("add_done_low", 32'(instr_done), 32'd0);

        // lw with 3 wait cycles in MEM_RD: 8 cycles total
        opcode = 6'b100011;
        tick;
        tick;
        chk("lw_ma_state", 32'(state), 32'd2);
        chk("lw_ma_srcb", 32'(alu_src_b), 32'd2);
        tick;
        mem_ready = 1'b0; #1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (state !== 4'd3 || reg_write !== 1'b0 || mem_read !== 1'b1 || i_or_d !== 1'b1)
                bad++;
            tick;
        end
        chk("lw_wait_cycles", 32'(bad), 32'd0);
        mem_ready = 1'b1; #1;
        chk("lw_rd_last", 32'(state), 32'd3);
        tick;
        chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_rw", 32'(reg_write), 32'd1);
        chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
        tick;
        chk("lw_cnt", instr_count, 32'd2);

        // branches
        do_branch("beq_z1", 6'b000100, 1'b1, 1'b1);
        do_branch("beq_z0", 6'b000100, 1'b0, 1'b0);
        do_branch("bne_z0", 6'b000101, 1'b0, 1'b1);
        chk("br_cnt", instr_count, 32'd5);

        // sw, zero wait: 4 cycles
        opcode = 6'b101011;
        tick; tick; tick;
        chk("sw_state", 32'(state), 32'd5);
        chk("sw_mem_write", 32'(mem_write), 32'd1);
        chk("sw_done", 32'(instr_done), 32'd1);
        tick;
        chk("sw_cnt", instr_count, 32'd6);

        // ori: zero-extended immediate
        opcode = 6'b001101;
        tick; tick;
        chk("ori_state", 32'(state), 32'd8);
        chk("ori_ext", 32'(ext_op), 32'd0);
        chk("ori_aluop", 32'(alu_op), 32'd3);
        tick;
        chk("ori_wb_rw", 32'(reg_write), 32'd1);
        chk("ori_wb_dst", 32'(reg_dst), 32'd0);
        tick;
        chk("ori_cnt", instr_count, 32'd7);

        // counter wrap via two jumps from a preset count
        force dut.instr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt_q;
        #1;
        chk("wrap_preset", instr_count, 32'hFFFF_FFFF);
        opcode = 6'b000010;
        tick; tick;
        chk("j_state", 32'(state), 32'd11);
        chk("j_pc_we", 32'(pc_we), 32'd1);
        chk("j_pc_src", 32'(pc_src), 32'd2);
        tick;
        chk("wrap_zero", instr_count, 32'd0);
        tick; tick; tick;
        chk("wrap_one", instr_count, 32'd1);

        // illegal opcode
        opcode = 6'b111111;
        tick;
        chk("ill_decode", 32'(state), 32'd1);
        tick;
        chk("ill_halt", 32'(state), 32'd12);
        chk("ill_err", 32'(err), 32'd1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (err !== 1'b1 || state !== 4'd12 || mem_read !== 1'b0 || pc_we !== 1'b0) bad++;
        end
        chk("ill_hold", 32'(bad), 32'd0);
        chk("ill_cnt", instr_count, 32'd1);
        reset = 1'b1; #1;
        chk("ill_rst_err", 32'(err), 32'd0);
        chk("ill_rst_state", 32'(state), 32'd0);
        tick;
        reset = 1'b0;

        // FETCH timeout after 4 wait cycles
        opcode = 6'd0; mem_ready = 1'b0; #1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (state !== 4'd0) bad++;
            tick;
        end
        chk("to_waits", 32'(bad), 32'd0);
        chk("to_halt", 32'(state), 32'd12);
        chk("to_err", 32'(err), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0; #1;

        // mem_ready on wait cycle 4 wins
        tick; tick; tick;
        mem_ready = 1'b1; #1;
        chk("tor_fetch", 32'(state), 32'd0);
        tick;
        chk("tor_decode", 32'(state), 32'd1);
        chk("tor_err", 32'(err), 32'd0);

        // reset mid-instruction in EXEC_R
        tick;
        chk("abort_exec", 32'(state), 32'd6);
        reset = 1'b1; #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_rw", 32'(reg_write), 32'd0);
        tick;
        chk("abort_rw_hold", 32'(reg_write), 32'd0);
        chk("abort_cnt", instr_count, 32'd0);
        reset = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
